// File: rtl/eeprom_wr.sv
// I2C master for 24Cxx-style EEPROMs: single-byte write and random-address single-byte read.
// Build option ACK_CHECK_EN: a slave NACK aborts to STOP and pulses err; undefined, acknowledges are ignored.
module eeprom_wr #(
   parameter int unsigned QTR = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr,
   input  logic        rd,
   input  logic [10:0] addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        scl,
   inout  wire         sda
);

   // state    | meaning
   // IDLE     | bus idle, scl=1, sda released, waiting for wr/rd
   // START    | start condition slot
   // CTRL     | control byte, write direction
   // ACK1     | slave ack of control byte
   // ADDR     | byte address A7..A0
   // ACK2     | slave ack of address
   // DATA_W   | write data byte
   // ACK3     | slave ack of write data
   // RSTART   | repeated start before read control byte
   // CTRL_R   | control byte, read direction
   // ACK4     | slave ack of read control byte
   // DATA_R   | slave drives read data, sda released
   // NACK     | master NACK ends the read
   // STOP     | stop condition slot
   typedef enum logic [3:0] {
      S_IDLE, S_START, S_CTRL, S_ACK1, S_ADDR, S_ACK2, S_DATA_W, S_ACK3,
      S_RSTART, S_CTRL_R, S_ACK4, S_DATA_R, S_NACK, S_STOP
   } state_t;

   localparam logic [7:0] QTR_LD = 8'(QTR - 1);

   state_t      state, state_nx;
   logic [7:0]  qtr_cnt;
   logic [1:0]  quarter;
   logic [2:0]  bit_cnt;
   logic [10:0] addr_q;
   logic [7:0]  data_q;
   logic        is_rd;
   logic [7:0]  rx_sh;
   logic [7:0]  tx_byte;
   logic        accept, slot_end, sample_tick, byte_last, is_byte, finishing;
   logic        ack_fail, aborted;
   logic        scl_c, sda_oe, sda_o;

   assign accept      = (state == S_IDLE) && (wr || rd);
   assign slot_end    = (quarter == 2'd3) && (qtr_cnt == 8'd0);
   assign sample_tick = (quarter == 2'd1) && (qtr_cnt == 8'd0);
   assign byte_last   = (bit_cnt == 3'd7);
   assign finishing   = (state == S_STOP) && slot_end;
   assign is_byte     = (state == S_CTRL) || (state == S_ADDR) || (state == S_DATA_W) ||
                        (state == S_CTRL_R) || (state == S_DATA_R);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (wr || rd)             state_nx = S_START;
         S_START:  if (slot_end)             state_nx = S_CTRL;
         S_CTRL:   if (slot_end && byte_last) state_nx = S_ACK1;
         S_ACK1:   if (slot_end)             state_nx = ack_fail ? S_STOP : S_ADDR;
         S_ADDR:   if (slot_end && byte_last) state_nx = S_ACK2;
         S_ACK2:   if (slot_end)             state_nx = ack_fail ? S_STOP :
                                                        (is_rd ? S_RSTART : S_DATA_W);
         S_DATA_W: if (slot_end && byte_last) state_nx = S_ACK3;
         S_ACK3:   if (slot_end)             state_nx = S_STOP;
         S_RSTART: if (slot_end)             state_nx = S_CTRL_R;
         S_CTRL_R: if (slot_end && byte_last) state_nx = S_ACK4;
         S_ACK4:   if (slot_end)             state_nx = ack_fail ? S_STOP : S_DATA_R;
         S_DATA_R: if (slot_end && byte_last) state_nx = S_NACK;
         S_NACK:   if (slot_end)             state_nx = S_STOP;
         S_STOP:   if (slot_end)             state_nx = S_IDLE;
         default:                            state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      tx_byte = 8'h00;
      case (state)
         S_CTRL:   tx_byte = {4'b1010, addr_q[10:8], 1'b0};
         S_CTRL_R: tx_byte = {4'b1010, addr_q[10:8], 1'b1};
         S_ADDR:   tx_byte = addr_q[7:0];
         S_DATA_W: tx_byte = data_q;
         default:  tx_byte = 8'h00;
      endcase
   end

   // Bit slots shape scl as low/high/high/low across the four quarters.
   always_comb begin
      scl_c  = 1'b1;
      sda_oe = 1'b0;
      sda_o  = 1'b1;
      case (state)
         S_IDLE: ;
         S_START, S_RSTART: begin
            scl_c  = (quarter == 2'd1) || (quarter == 2'd2);
            sda_oe = 1'b1;
            sda_o  = (quarter < 2'd2);
         end
         S_STOP: begin
            scl_c  = (quarter != 2'd0);
            sda_oe = (quarter < 2'd2);
            sda_o  = 1'b0;
         end
         S_CTRL, S_ADDR, S_DATA_W, S_CTRL_R: begin
            scl_c  = (quarter == 2'd1) || (quarter == 2'd2);
            sda_oe = 1'b1;
            sda_o  = tx_byte[~bit_cnt];
         end
         S_NACK: begin
            scl_c  = (quarter == 2'd1) || (quarter == 2'd2);
            sda_oe = 1'b1;
            sda_o  = 1'b1;
         end
         default: scl_c = (quarter == 2'd1) || (quarter == 2'd2);
      endcase
   end

   assign scl  = scl_c;
   assign sda  = sda_oe ? sda_o : 1'bz;
   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         qtr_cnt <= 8'd0;
         quarter <= 2'd0;
         bit_cnt <= 3'd0;
      end else if (state == S_IDLE) begin
         qtr_cnt <= accept ? QTR_LD : 8'd0;
         quarter <= 2'd0;
         bit_cnt <= 3'd0;
      end else begin
         if (qtr_cnt == 8'd0) begin
            qtr_cnt <= QTR_LD;
            quarter <= quarter + 2'd1;
         end else begin
            qtr_cnt <= qtr_cnt - 8'd1;
         end
         if (slot_end && is_byte) bit_cnt <= bit_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q   <= 11'd0;
         data_q   <= 8'd0;
         is_rd    <= 1'b0;
         rx_sh    <= 8'd0;
         data_out <= 8'd0;
         done     <= 1'b0;
      end else begin
         done <= finishing && !aborted;
         if (accept) begin
            addr_q <= addr;
            data_q <= data_in;
            is_rd  <= !wr;
         end
         if ((state == S_DATA_R) && sample_tick) rx_sh <= {rx_sh[6:0], sda};
         if (finishing && is_rd && !aborted) data_out <= rx_sh;
      end
   end

`ifdef ACK_CHECK_EN
   logic ack_bit, nack_flag, err_q, is_ack;

   assign is_ack = (state == S_ACK1) || (state == S_ACK2) ||
                   (state == S_ACK3) || (state == S_ACK4);

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_bit   <= 1'b0;
         nack_flag <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         err_q <= finishing && nack_flag;
         if (sample_tick) ack_bit <= sda;
         if (accept)                                nack_flag <= 1'b0;
         else if (is_ack && slot_end && ack_bit)    nack_flag <= 1'b1;
      end
   end

   assign ack_fail = ack_bit;
   assign aborted  = nack_flag;
   assign err      = err_q;
`else
   assign ack_fail = 1'b0;
   assign aborted  = 1'b0;
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_wr.sv
// Directed bench for eeprom_wr with a behavioural 24Cxx slave on a pulled-up sda line.
module tb_eeprom_wr;
   localparam int QTR    = 2;
   localparam int WR_CYC = 29 * 4 * QTR;
   localparam int RD_CYC = 39 * 4 * QTR;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr = 1'b0, rd = 1'b0;
   logic [10:0] addr = 11'd0;
   logic [7:0]  data_in = 8'd0;
   logic [7:0]  data_out;
   logic        busy, done, err, scl;
   wire         sda;

   int n_cmp = 0;
   int n_fail = 0;

   pullup (sda);

   eeprom_wr #(.QTR(QTR)) dut (
      .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .data_in(data_in),
      .data_out(data_out), .busy(busy), .done(done), .err(err), .scl(scl), .sda(sda)
   );

   always #5 clk = ~clk;

   // ---------------- EEPROM slave model ----------------
   logic       drv_low = 1'b0;
   assign sda = drv_low ? 1'b0 : 1'bz;

   logic [7:0]  mem [0:2047];
   logic        p_scl = 1'b1, p_sda = 1'b1;
   logic        active = 1'b0, ign = 1'b0, slave_tx = 1'b0, rd_mode = 1'b0;
   logic        force_nack = 1'b0, mnack = 1'b0, pend_val = 1'b0;
   int          pend_cnt = 0, bitn = 0, byte_no = 0, starts = 0, stops = 0;
   logic [7:0]  sh = 8'd0, tx = 8'd0;
   logic [2:0]  blk = 3'd0;
   logic [10:0] ptr = 11'd0;
   logic [7:0]  bus_q [$];

   // New drive levels wait QTR clocks after scl falls so they land after the master's Q0 release.
   always @(negedge clk) begin
      logic s, d;
      s = scl;
      d = sda;
      if (reset) begin
         active = 1'b0; ign = 1'b0; slave_tx = 1'b0; drv_low = 1'b0; pend_cnt = 0;
      end else begin
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) drv_low = pend_val;
         end
         if (p_scl && s && p_sda && !d) begin
            active = 1'b1; ign = 1'b0; slave_tx = 1'b0; bitn = 0; byte_no = 0;
            starts++; drv_low = 1'b0; pend_cnt = 0;
         end else if (p_scl && s && !p_sda && d) begin
            active = 1'b0; slave_tx = 1'b0; stops++; drv_low = 1'b0; pend_cnt = 0;
         end else if (active && !p_scl && s) begin
            if (bitn < 8) sh = {sh[6:0], d};
            else if (slave_tx) mnack = d;
            bitn++;
         end else if (active && p_scl && !s) begin
            if (bitn == 8) begin
               bus_q.push_back(sh);
               if (slave_tx) begin
                  drv_low = 1'b0; pend_cnt = 0;
               end else if (!ign) begin
                  if (byte_no == 0) begin
                     if (force_nack || sh[7:4] != 4'b1010) ign = 1'b1;
                     else begin
                        rd_mode = sh[0];
                        if (!sh[0]) blk = sh[3:1];
                     end
                  end else if (byte_no == 1) begin
                     ptr = {blk, sh};
                  end else begin
                     mem[ptr] = sh;
                     ptr++;
                  end
                  if (!ign) begin pend_val = 1'b1; pend_cnt = QTR; end
               end
               byte_no++;
            end else if (bitn == 9) begin
               bitn = 0; drv_low = 1'b0; pend_cnt = 0;
               if (slave_tx) slave_tx = 1'b0;
               else if (rd_mode && byte_no == 1 && !ign) begin
                  slave_tx = 1'b1; tx = mem[ptr];
                  pend_val = !tx[7]; pend_cnt = QTR;
               end
            end else if (slave_tx) begin
               pend_val = !tx[7 - bitn]; pend_cnt = QTR;
            end
         end
      end
      p_scl = s;
      p_sda = d;
   end

   // ---------------- stimulus helpers ----------------
   task automatic run_txn(input logic w, input logic r, input logic [10:0] a, input logic [7:0] d,
                          input int rd_pulse_at, output int cyc, output logic busy0,
                          output logic saw_done, output logic saw_err);
      @(negedge clk);
      wr = w; rd = r; addr = a; data_in = d;
      @(posedge clk);
      @(negedge clk);
      wr = 1'b0; rd = 1'b0; addr = ~a; data_in = ~d;
      busy0 = busy;
      cyc = 0; saw_done = 1'b0; saw_err = 1'b0;
      while (cyc < 1000 && !saw_done && !saw_err) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         rd = (cyc == rd_pulse_at);
         saw_done = done;
         saw_err = err;
      end
      rd = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b want 1", scl); end
      n_cmp++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1 (released)", sda); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out); end
      reset = 1'b0;
   endtask

   task automatic test_write();
      int cyc; logic b0, sd, se;
      bus_q.delete();
      run_txn(1'b1, 1'b0, 11'h5A3, 8'hC3, -1, cyc, b0, sd, se);
      n_cmp++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL wr_busy_set: got %b want 1", b0); end
      n_cmp++; if (cyc !== WR_CYC) begin n_fail++; $display("FAIL wr_done_cycle: got %0d want %0d", cyc, WR_CYC); end
      n_cmp++; if (sd !== 1'b1 || se !== 1'b0) begin n_fail++; $display("FAIL wr_done_err: done %b err %b want 1 0", sd, se); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_fall: got %b want 0", busy); end
      n_cmp++; if (bus_q.size() !== 3) begin n_fail++; $display("FAIL wr_byte_count: got %0d want 3", bus_q.size()); end
      else begin
         n_cmp++; if (bus_q[0] !== 8'hAA) begin n_fail++; $display("FAIL wr_ctrl: got %h want AA", bus_q[0]); end
         n_cmp++; if (bus_q[1] !== 8'hA3) begin n_fail++; $display("FAIL wr_addr: got %h want A3", bus_q[1]); end
         n_cmp++; if (bus_q[2] !== 8'hC3) begin n_fail++; $display("FAIL wr_data: got %h want C3", bus_q[2]); end
      end
      n_cmp++; if (mem[11'h5A3] !== 8'hC3) begin n_fail++; $display("FAIL wr_mem: got %h want C3", mem[11'h5A3]); end
      n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL wr_data_out_hold: got %h want 00", data_out); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL wr_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_read();
      int cyc, st0; logic b0, sd, se;
      bus_q.delete();
      st0 = starts; mnack = 1'b0;
      run_txn(1'b0, 1'b1, 11'h5A3, 8'h00, -1, cyc, b0, sd, se);
      n_cmp++; if (cyc !== RD_CYC) begin n_fail++; $display("FAIL rd_done_cycle: got %0d want %0d", cyc, RD_CYC); end
      n_cmp++; if (data_out !== 8'hC3) begin n_fail++; $display("FAIL rd_data_out: got %h want C3", data_out); end
      n_cmp++; if (starts - st0 !== 2) begin n_fail++; $display("FAIL rd_restart: got %0d starts want 2", starts - st0); end
      n_cmp++; if (mnack !== 1'b1) begin n_fail++; $display("FAIL rd_master_nack: got %b want 1", mnack); end
      n_cmp++; if (bus_q.size() !== 4) begin n_fail++; $display("FAIL rd_byte_count: got %0d want 4", bus_q.size()); end
      else begin
         n_cmp++; if (bus_q[0] !== 8'hAA) begin n_fail++; $display("FAIL rd_ctrl_w: got %h want AA", bus_q[0]); end
         n_cmp++; if (bus_q[1] !== 8'hA3) begin n_fail++; $display("FAIL rd_addr: got %h want A3", bus_q[1]); end
         n_cmp++; if (bus_q[2] !== 8'hAB) begin n_fail++; $display("FAIL rd_ctrl_r: got %h want AB", bus_q[2]); end
         n_cmp++; if (bus_q[3] !== 8'hC3) begin n_fail++; $display("FAIL rd_bus_data: got %h want C3", bus_q[3]); end
      end
      repeat (5) @(negedge clk);
      n_cmp++; if (data_out !== 8'hC3) begin n_fail++; $display("FAIL rd_data_hold: got %h want C3", data_out); end
   endtask

   task automatic test_back_to_back();
      int cyc, extra; logic b0, sd, se;
      bus_q.delete();
      run_txn(1'b1, 1'b1, 11'h000, 8'h55, 50, cyc, b0, sd, se);
      n_cmp++; if (cyc !== WR_CYC || sd !== 1'b1) begin n_fail++; $display("FAIL both_write_cycle: got %0d done %b want %0d 1", cyc, sd, WR_CYC); end
      n_cmp++; if (bus_q.size() !== 3) begin n_fail++; $display("FAIL both_byte_count: got %0d want 3", bus_q.size()); end
      else begin
         n_cmp++; if (bus_q[0] !== 8'hA0) begin n_fail++; $display("FAIL both_ctrl: got %h want A0", bus_q[0]); end
      end
      n_cmp++; if (mem[11'h000] !== 8'h55) begin n_fail++; $display("FAIL both_mem: got %h want 55", mem[11'h000]); end
      extra = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL busy_rd_dropped: got %0d extra active cycles want 0", extra); end
   endtask

   task automatic test_reset_mid();
      int cyc; logic b0, sd, se;
      @(negedge clk);
      wr = 1'b1; addr = 11'h123; data_in = 8'h99;
      @(posedge clk);
      @(negedge clk);
      wr = 1'b0;
      for (int i = 1; i < 100; i++) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (scl !== 1'b1) begin n_fail++; $display("FAIL midrst_scl: got %b want 1", scl); end
      n_cmp++; if (sda !== 1'b1) begin n_fail++; $display("FAIL midrst_sda: got %b want 1 (released)", sda); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
      reset = 1'b0;
      n_cmp++; if (mem[11'h123] !== 8'hFF) begin n_fail++; $display("FAIL midrst_no_write: got %h want FF", mem[11'h123]); end
      run_txn(1'b1, 1'b0, 11'h7FF, 8'h12, -1, cyc, b0, sd, se);
      n_cmp++; if (cyc !== WR_CYC) begin n_fail++; $display("FAIL post_rst_wr_cycle: got %0d want %0d", cyc, WR_CYC); end
      run_txn(1'b0, 1'b1, 11'h7FF, 8'h00, -1, cyc, b0, sd, se);
      n_cmp++; if (data_out !== 8'h12) begin n_fail++; $display("FAIL post_rst_readback: got %h want 12", data_out); end
      n_cmp++; if (mem[11'h7FF] !== 8'h12) begin n_fail++; $display("FAIL post_rst_mem: got %h want 12", mem[11'h7FF]); end
   endtask

   task automatic test_ack_check();
      int cyc, sp0, late; logic b0, sd, se;
      force_nack = 1'b1;
      sp0 = stops;
      run_txn(1'b1, 1'b0, 11'h2AA, 8'h3C, -1, cyc, b0, sd, se);
      force_nack = 1'b0;
`ifdef ACK_CHECK_EN
      n_cmp++; if (cyc !== 11 * 4 * QTR) begin n_fail++; $display("FAIL nack_err_cycle: got %0d want %0d", cyc, 11 * 4 * QTR); end
      n_cmp++; if (se !== 1'b1 || sd !== 1'b0) begin n_fail++; $display("FAIL nack_err_done: err %b done %b want 1 0", se, sd); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nack_busy: got %b want 0", busy); end
      n_cmp++; if (stops - sp0 !== 1) begin n_fail++; $display("FAIL nack_stop: got %0d stops want 1", stops - sp0); end
`else
      n_cmp++; if (cyc !== WR_CYC) begin n_fail++; $display("FAIL noack_cycle: got %0d want %0d", cyc, WR_CYC); end
      n_cmp++; if (sd !== 1'b1 || se !== 1'b0) begin n_fail++; $display("FAIL noack_done_err: done %b err %b want 1 0", sd, se); end
`endif
      late = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (err === 1'b1 || done === 1'b1) late++;
      end
      n_cmp++; if (late !== 0) begin n_fail++; $display("FAIL ack_single_pulse: got %0d extra pulses want 0", late); end
      n_cmp++; if (data_out !== 8'h12) begin n_fail++; $display("FAIL ack_data_out_hold: got %h want 12", data_out); end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'hFF;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_mid();
      test_ack_check();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/eeprom_wr.md
EEPROM_WR -- requirements
Module: eeprom_wr

Interface
REQ-001 SHALL have parameter QTR, default 2, clk cycles per quarter-bit (legal 1..255); one SCL bit slot = 4*QTR clk cycles.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr  input  1  write request, sampled only in IDLE.
REQ-005 SHALL have port rd  input  1  read request, sampled only in IDLE.
REQ-006 SHALL have port addr  input  11  EEPROM byte address; A10..A8 select the block, A7..A0 select the byte.
REQ-007 SHALL have port data_in  input  8  write data.
REQ-008 SHALL have port data_out  output  8  last byte read.
REQ-009 SHALL have port busy  output  1  transaction in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  one-cycle NACK-abort pulse.
REQ-012 SHALL have port scl  output  1  I2C clock, driven push-pull.
REQ-013 SHALL have port sda  inout  1  I2C data; driven only when the internal link is set, else Z (bench pull-up).

Function
REQ-014 SHALL accept a request when busy=0 and wr or rd=1: latch addr and data_in, set busy on the next cycle; wr wins if both are high; requests while busy are ignored.
REQ-015 SHALL sequence the states IDLE, START, CTRL, ACK1, ADDR, ACK2, then either DATA_W, ACK3, STOP (write) or RSTART, CTRL_R, ACK4, DATA_R, NACK, STOP (read), then return to IDLE.
REQ-016 SHALL shape each data/ack slot as: Q0 scl=0 with sda updated at Q0 start; Q1,Q2 scl=1; Q3 scl=0.
REQ-017 SHALL shape START/RSTART slots as: Q0 scl=0 sda=1; Q1 scl=1 sda=1; Q2 scl=1 sda=0; Q3 scl=0 sda=0.
REQ-018 SHALL shape the STOP slot as: Q0 scl=0 sda=0; Q1 scl=1 sda=0; Q2,Q3 scl=1 sda released.
REQ-019 SHALL send control byte {4'b1010, A10..A8, 0} in CTRL and {4'b1010, A10..A8, 1} in CTRL_R, then A7..A0 in ADDR, then data_in in DATA_W, all MSB first via a 3-bit bit counter.
REQ-020 SHALL release sda throughout ACK1..ACK4 and DATA_R, and sample sda on the last clk of Q1.
REQ-021 SHALL drive sda=1 for the whole NACK slot after DATA_R.
REQ-022 SHALL, for a write, take 29 slots from START through STOP; done SHALL pulse on cycle 29*4*QTR after the accepting edge, and busy SHALL fall on that same cycle.
REQ-023 SHALL, for a read, take 39 slots; data_out SHALL update on the done cycle (39*4*QTR) and hold until the next successful read.
REQ-024 SHALL hold scl=1 with sda released in IDLE.

Reset
REQ-025 SHALL, when reset=1 at a clk edge, go to IDLE on that edge: scl=1, sda released, busy=0, done=0, err=0, data_out=8'h00, bit and quarter counters cleared.
REQ-026 SHALL abort any transaction in progress on reset without a STOP being generated; reset has priority over wr/rd on the same edge.

Configuration
REQ-027 SHALL, with ACK_CHECK_EN defined, treat sda=1 sampled in any ACK slot as a NACK: go to STOP, pulse err instead of done, leave data_out unchanged, and fall busy on the err cycle.
REQ-028 SHALL, without ACK_CHECK_EN, ignore the acknowledge value, tie err to 0, and always complete the full sequence.

Verification
REQ-029 SHALL verify, with QTR=2, wr and addr=11'h5A3, data_in=8'hC3 against the EEPROM model: bytes 8'hAA, 8'hA3, 8'hC3 on the bus; done at cycle 232; model memory[11'h5A3]=8'hC3.
REQ-030 SHALL verify that a subsequent rd of addr=11'h5A3 produces bus bytes 8'hAA, 8'hA3, a repeated START, then 8'hAB; data_out=8'hC3 at cycle 312; master NACK observed.
REQ-031 SHALL verify that wr and rd asserted together with addr=11'h000, data_in=8'h55 perform a write only, and that rd pulsed while busy is dropped (exactly one done).
REQ-032 SHALL verify that reset at cycle 100 of a write gives scl=1, sda=Z, busy=0 on the next cycle, and that a later write of 8'h12 to 11'h7FF reads back 8'h12.
REQ-033 SHALL verify, with ACK_CHECK_EN and a bench forcing sda=1 in ACK1: STOP generated, err pulses once, done stays 0, data_out unchanged.
REQ-034 SHALL verify, without ACK_CHECK_EN and the same forcing, that the full 29-slot write completes with done pulsing and err=0.
